mux81_scan_ctrl: RTL and testbench

Upstream control stage for the 4-bit 8:1 bus mux (BS_4_MUX81).
- Holds the eight channel registers that drive the mux data inputs A0..A7.
- Sequences the 3-bit select through channels 0..7 with a programmable dwell per channel.
- Captures the mux output into a registered sample stream tagged with the channel index, giving a single- or continuous-scan readout of the bank.

---
 rtl/mux81_scan_ctrl_pkg.sv | 17 +
 rtl/mux81_chan_bank.sv | 49 ++++
 rtl/mux81_scan_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mux81_scan_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux81_scan_ctrl_pkg.sv
// Shared types and sizes for the 8:1 mux scan controller and its channel bank.
package mux81_scan_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    localparam int unsigned NUM_CH      = 8;
    localparam int unsigned SEL_W       = 3;
    localparam int unsigned DEF_W       = 4;
    localparam int unsigned DEF_DWELL_W = 8;

    // Last channel index, used for pass wrap / termination.
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

endpackage

// File: rtl/mux81_chan_bank.sv
// Eight write-addressed channel registers that feed mux data inputs A0..A7.
module mux81_chan_bank
    import mux81_scan_ctrl_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_addr,
    input  logic [W-1:0]     wr_data,
    output logic [W-1:0]     ch0,
    output logic [W-1:0]     ch1,
    output logic [W-1:0]     ch2,
    output logic [W-1:0]     ch3,
    output logic [W-1:0]     ch4,
    output logic [W-1:0]     ch5,
    output logic [W-1:0]     ch6,
    output logic [W-1:0]     ch7
);

    logic [W-1:0] bank_q [NUM_CH];
    logic [W-1:0] bank_d [NUM_CH];

    always_comb begin
        bank_d = bank_q;
        if (wr_en) begin
            bank_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_q <= '{default: '0};
        end else begin
            bank_q <= bank_d;
        end
    end

    assign ch0 = bank_q[0];
    assign ch1 = bank_q[1];
    assign ch2 = bank_q[2];
    assign ch3 = bank_q[3];
    assign ch4 = bank_q[4];
    assign ch5 = bank_q[5];
    assign ch6 = bank_q[6];
    assign ch7 = bank_q[7];

endmodule

// File: rtl/mux81_scan_ctrl.sv
// Scan controller for the 4-bit 8:1 bus mux: channel bank, select sequencer with
// programmable dwell, and tagged capture of the mux output.
module mux81_scan_ctrl
    import mux81_scan_ctrl_pkg::*;
#(
    parameter int unsigned W       = DEF_W,
    parameter int unsigned DWELL_W = DEF_DWELL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [2:0]         wr_addr,
    input  logic [W-1:0]       wr_data,
    input  logic               start,
    input  logic               cont,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               stop,
    output logic [W-1:0]       ch0,
    output logic [W-1:0]       ch1,
    output logic [W-1:0]       ch2,
    output logic [W-1:0]       ch3,
    output logic [W-1:0]       ch4,
    output logic [W-1:0]       ch5,
    output logic [W-1:0]       ch6,
    output logic [W-1:0]       ch7,
    output logic [2:0]         sel,
    input  logic [W-1:0]       mux_data,
    output logic [W-1:0]       out_data,
    output logic [2:0]         out_ch,
    output logic               out_valid,
    output logic               busy,
    output logic               done
);

    state_e             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] deff_q, deff_d;
    logic               cont_q, cont_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [W-1:0]       out_data_q, out_data_d;
    logic [SEL_W-1:0]   out_ch_q, out_ch_d;
    logic               out_valid_q, out_valid_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic               start_ok_c;
    logic               capture_c;
    logic               last_c;
    logic [DWELL_W-1:0] dwell_eff_c;

    mux81_chan_bank #(
        .W (W)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .ch0     (ch0),
        .ch1     (ch1),
        .ch2     (ch2),
        .ch3     (ch3),
        .ch4     (ch4),
        .ch5     (ch5),
        .ch6     (ch6),
        .ch7     (ch7)
    );

    // Stop outranks both a new start and a coincident capture.
    assign start_ok_c  = (state_q == ST_IDLE) && start && !stop;
    assign capture_c   = (state_q == ST_SCAN) && !stop && (cnt_q == '0);
    assign last_c      = capture_c && (sel_q == LAST_CH) && !cont_q;
    assign dwell_eff_c = (dwell == '0) ? DWELL_W'(1) : dwell;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            deff_q      <= '0;
            cont_q      <= 1'b0;
            sel_q       <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            deff_q      <= deff_d;
            cont_q      <= cont_d;
            sel_q       <= sel_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_c) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (stop || last_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Dwell counting, select sequencing and sample capture.
    always_comb begin
        cnt_d       = cnt_q;
        deff_d      = deff_q;
        cont_d      = cont_q;
        sel_d       = sel_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sel_d = '0;
                if (start_ok_c) begin
                    cont_d = cont;
                    deff_d = dwell_eff_c;
                    cnt_d  = dwell_eff_c - DWELL_W'(1);
                end
            end
            ST_SCAN: begin
                if (stop) begin
                    sel_d = '0;
                    cnt_d = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else begin
                    out_data_d  = mux_data;
                    out_ch_d    = sel_q;
                    out_valid_d = 1'b1;
                    cnt_d       = deff_q - DWELL_W'(1);
                    if (sel_q != LAST_CH) begin
                        sel_d = sel_q + SEL_W'(1);
                    end else begin
                        sel_d  = '0;
                        done_d = !cont_q;
                    end
                end
            end
            default: sel_d = '0;
        endcase
    end

    assign busy_d = (state_d == ST_SCAN);

    assign sel       = sel_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mux81_scan_ctrl.sv
// Directed bench for mux81_scan_ctrl with a behavioural 8:1 mux closing the loop.
module tb_mux81_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic [7:0] dwell = '0;
    logic       stop = 1'b0;
    logic [3:0] ch0, ch1, ch2, ch3, ch4, ch5, ch6, ch7;
    logic [2:0] sel;
    logic [3:0] mux_data;
    logic [3:0] out_data;
    logic [2:0] out_ch;
    logic       out_valid, busy, done;

    int total = 0;
    int bad   = 0;

    logic [3:0] pat [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                            4'b1100, 4'b1110, 4'b0111, 4'b1111};

    always #5 clk = ~clk;

    mux81_scan_ctrl #(.W(4), .DWELL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .cont(cont), .dwell(dwell), .stop(stop),
        .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3), .ch4(ch4), .ch5(ch5), .ch6(ch6), .ch7(ch7),
        .sel(sel), .mux_data(mux_data), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .busy(busy), .done(done)
    );

    // Stand-in for the combinational BS_4_MUX81.
    always_comb begin
        case (sel)
            3'd0: mux_data = ch0;
            3'd1: mux_data = ch1;
            3'd2: mux_data = ch2;
            3'd3: mux_data = ch3;
            3'd4: mux_data = ch4;
            3'd5: mux_data = ch5;
            3'd6: mux_data = ch6;
            default: mux_data = ch7;
        endcase
    end

    function automatic logic [3:0] get_ch(input int k);
        case (k)
            0: return ch0;
            1: return ch1;
            2: return ch2;
            3: return ch3;
            4: return ch4;
            5: return ch5;
            6: return ch6;
            default: return ch7;
        endcase
    endfunction

    task automatic write_ch(input logic [2:0] a, input logic [3:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] dw, input logic c);
        @(negedge clk);
        start = 1'b1; dwell = dw; cont = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (sel !== 3'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", sel); end
        total++; if (out_data !== 4'd0) begin bad++; $display("FAIL reset_out_data got=%b exp=0000", out_data); end
        total++; if (out_ch !== 3'd0) begin bad++; $display("FAIL reset_out_ch got=%0d exp=0", out_ch); end
        for (int k = 0; k < 8; k++) begin
            total++; if (get_ch(k) !== 4'd0) begin bad++; $display("FAIL reset_ch%0d got=%b exp=0000", k, get_ch(k)); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_bank_write();
        for (int k = 0; k < 8; k++) write_ch(3'(k), pat[k]);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            total++; if (get_ch(k) !== pat[k]) begin bad++; $display("FAIL bank_ch%0d got=%b exp=%b", k, get_ch(k), pat[k]); end
        end
    endtask

    // Single pass: cycle i counts edges after the accepting edge T0.
    task automatic test_single(input logic [7:0] dw);
        int deff, n, k;
        logic ev, ed, eb;
        logic [2:0] es;
        deff = (dw == 0) ? 1 : int'(dw);
        n = 0;
        do_start(dw, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_d%0d_busy0 got=%b exp=1", dw, busy); end
        total++; if (sel !== 3'd0) begin bad++; $display("FAIL single_d%0d_sel0 got=%0d exp=0", dw, sel); end
        for (int i = 1; i <= 8 * deff + 3; i++) begin
            @(negedge clk);
            ev = (i % deff == 0) && (i <= 8 * deff);
            ed = (i == 8 * deff);
            eb = (i < 8 * deff);
            es = (i < 8 * deff) ? 3'(i / deff) : 3'd0;
            k  = i / deff - 1;
            total++; if (out_valid !== ev) begin bad++; $display("FAIL single_d%0d_valid c=%0d got=%b exp=%b", dw, i, out_valid, ev); end
            total++; if (done !== ed) begin bad++; $display("FAIL single_d%0d_done c=%0d got=%b exp=%b", dw, i, done, ed); end
            total++; if (busy !== eb) begin bad++; $display("FAIL single_d%0d_busy c=%0d got=%b exp=%b", dw, i, busy, eb); end
            total++; if (sel !== es) begin bad++; $display("FAIL single_d%0d_sel c=%0d got=%0d exp=%0d", dw, i, sel, es); end
            if (out_valid === 1'b1) n++;
            if (ev) begin
                total++; if (out_ch !== 3'(k)) begin bad++; $display("FAIL single_d%0d_ch c=%0d got=%0d exp=%0d", dw, i, out_ch, k); end
                total++; if (out_data !== pat[k]) begin bad++; $display("FAIL single_d%0d_data c=%0d got=%b exp=%b", dw, i, out_data, pat[k]); end
            end
        end
        total++; if (n != 8) begin bad++; $display("FAIL single_d%0d_count got=%0d exp=8", dw, n); end
    endtask

    task automatic test_continuous_stop();
        int k;
        logic ev;
        do_start(8'd2, 1'b1);
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            ev = (i % 2 == 0);
            k  = (i / 2 - 1) % 8;
            total++; if (out_valid !== ev) begin bad++; $display("FAIL cont_valid c=%0d got=%b exp=%b", i, out_valid, ev); end
            total++; if (done !== 1'b0) begin bad++; $display("FAIL cont_done c=%0d got=%b exp=0", i, done); end
            total++; if (sel !== 3'((i / 2) % 8)) begin bad++; $display("FAIL cont_sel c=%0d got=%0d exp=%0d", i, sel, (i / 2) % 8); end
            if (ev) begin
                total++; if (out_ch !== 3'(k)) begin bad++; $display("FAIL cont_ch c=%0d got=%0d exp=%0d", i, out_ch, k); end
                total++; if (out_data !== pat[k]) begin bad++; $display("FAIL cont_data c=%0d got=%b exp=%b", i, out_data, pat[k]); end
            end
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_busy got=%b exp=0", busy); end
        total++; if (sel !== 3'd0) begin bad++; $display("FAIL stop_sel got=%0d exp=0", sel); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stop_valid got=%b exp=0", out_valid); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++; if ((out_valid | done) !== 1'b0) begin bad++; $display("FAIL stop_quiet c=%0d valid=%b done=%b exp=0", i, out_valid, done); end
        end
    endtask

    // dwell=4 pass: ch5 captured at cycle 24; write lands on edge wcyc+1.
    task automatic scan_with_write(input int wcyc, input logic [3:0] wd, input logic [3:0] expd);
        int n;
        n = 0;
        do_start(8'd4, 1'b0);
        for (int i = 1; i <= 34; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) n++;
            if (i == 24) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL wr_w%0d_valid got=%b exp=1", wcyc, out_valid); end
                total++; if (out_ch !== 3'd5) begin bad++; $display("FAIL wr_w%0d_ch got=%0d exp=5", wcyc, out_ch); end
                total++; if (out_data !== expd) begin bad++; $display("FAIL wr_w%0d_data got=%b exp=%b", wcyc, out_data, expd); end
            end
            if (i == 32) begin
                total++; if (done !== 1'b1) begin bad++; $display("FAIL wr_w%0d_done got=%b exp=1", wcyc, done); end
            end
            if (i == wcyc) begin
                wr_en = 1'b1; wr_addr = 3'd5; wr_data = wd;
            end else if (i == wcyc + 1) begin
                wr_en = 1'b0;
            end
        end
        total++; if (n != 8) begin bad++; $display("FAIL wr_w%0d_count got=%0d exp=8", wcyc, n); end
    endtask

    task automatic test_write_during_scan();
        scan_with_write(21, 4'b1010, 4'b1010);
        scan_with_write(23, 4'b0101, 4'b1010);
        total++; if (ch5 !== 4'b0101) begin bad++; $display("FAIL wr_ch5_after got=%b exp=0101", ch5); end
        write_ch(3'd5, pat[5]);
    endtask

    task automatic test_back_to_back_start();
        int n, nd;
        n = 0; nd = 0;
        do_start(8'd1, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            total++; if (out_valid !== (i <= 8)) begin bad++; $display("FAIL restart_valid c=%0d got=%b exp=%b", i, out_valid, (i <= 8)); end
            if (out_valid === 1'b1) n++;
            if (done === 1'b1) nd++;
            if (i == 3) begin
                start = 1'b1; dwell = 8'd5; cont = 1'b1;
            end else if (i == 4) begin
                start = 1'b0; dwell = 8'd1; cont = 1'b0;
            end
        end
        total++; if (n != 8) begin bad++; $display("FAIL restart_count got=%0d exp=8", n); end
        total++; if (nd != 1) begin bad++; $display("FAIL restart_done_count got=%0d exp=1", nd); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL restart_busy got=%b exp=0", busy); end
    endtask

    task automatic test_stop_on_capture();
        do_start(8'd2, 1'b0);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stopcap_valid got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stopcap_busy got=%b exp=0", busy); end
        total++; if (sel !== 3'd0) begin bad++; $display("FAIL stopcap_sel got=%0d exp=0", sel); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL stopcap_done got=%b exp=0", done); end
        @(negedge clk);
        start = 1'b1; stop = 1'b1; dwell = 8'd1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            total++; if ((busy | out_valid) !== 1'b0) begin bad++; $display("FAIL startstop c=%0d busy=%b valid=%b exp=0", i, busy, out_valid); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_scan();
        int n;
        n = 0;
        do_start(8'd2, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        total++; if (sel !== 3'd0) begin bad++; $display("FAIL rstmid_sel got=%0d exp=0", sel); end
        total++; if (out_data !== 4'd0) begin bad++; $display("FAIL rstmid_data got=%b exp=0000", out_data); end
        total++; if (out_ch !== 3'd0) begin bad++; $display("FAIL rstmid_ch got=%0d exp=0", out_ch); end
        for (int k = 0; k < 8; k++) begin
            total++; if (get_ch(k) !== 4'd0) begin bad++; $display("FAIL rstmid_ch%0d got=%b exp=0000", k, get_ch(k)); end
        end
        for (int i = 0; i < 20; i++) begin
            total++; if ((out_valid | done | busy) !== 1'b0) begin bad++; $display("FAIL rstmid_quiet c=%0d valid=%b done=%b busy=%b", i, out_valid, done, busy); end
            if (out_valid === 1'b1) n++;
            @(negedge clk);
        end
        total++; if (n != 0) begin bad++; $display("FAIL rstmid_count got=%0d exp=0", n); end
    endtask

    initial begin
        test_reset();
        test_bank_write();
        test_single(8'd1);
        test_single(8'd3);
        test_single(8'd0);
        test_continuous_stop();
        test_write_during_scan();
        test_back_to_back_start();
        test_stop_on_capture();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
